// File: rtl/rv32i_boot_loader.sv
// rv32i_boot_loader: synthesizable boot stage for the rv32i core.
// Receives a little-endian byte stream
//   load address (4 B) | word count N (4 B) | N instruction words (4 B each) | [checksum (1 B)]
// writes each word into instruction memory, then releases the core from reset
// with pc_init_o set to the load address.
// Optional feature macro: CHECKSUM_EN adds a trailing XOR checksum byte and the CHECK state.
module rv32i_boot_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int RST_HOLD  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_rst_o,
  output logic [31:0] pc_init_o,
  output logic        done_o,
  output logic        err_o
);

  // Word index / count width: must hold MAX_WORDS itself.
  localparam int IW = $clog2(MAX_WORDS + 1);
  // Hold counter width: must hold RST_HOLD itself.
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    ST_HDR_ADDR,
    ST_HDR_LEN,
    ST_PAYLOAD,
`ifdef CHECKSUM_EN
    ST_CHECK,
`endif
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_t;

  // State entered once the last payload word (or an empty image) has been seen.
`ifdef CHECKSUM_EN
  localparam state_t ST_AFTER_LOAD = ST_CHECK;
`else
  localparam state_t ST_AFTER_LOAD = ST_HOLD;
`endif

  state_t      state_reg;
  state_t      state_next;

  logic [1:0]    cnt_reg;
  logic [31:0]   word_reg;
  logic [31:0]   word_next;
  logic [31:0]   pc_reg;
  logic [IW-1:0] n_reg;
  logic [IW-1:0] idx_reg;
  logic [HW-1:0] hold_reg;

  logic          ready_reg;
  logic          ready_next;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic          core_rst_reg;
  logic          done_reg;
  logic          err_reg;

`ifdef CHECKSUM_EN
  logic [7:0]    xor_reg;
`endif

  logic accept;
  logic field_done;
  logic last_word;
  logic len_too_big;
  logic len_zero;

  assign accept      = byte_valid_i & ready_reg;
  assign field_done  = accept & (cnt_reg == 2'd3);
  assign last_word   = (idx_reg == (n_reg - IW'(1)));
  assign len_too_big = (word_next > 32'(MAX_WORDS));
  assign len_zero    = (word_next == 32'd0);

  // Insert the incoming byte into its lane of the word being assembled (LSB first).
  always_comb begin
    word_next = word_reg;
    word_next[{cnt_reg, 3'b000} +: 8] = byte_data_i;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_HDR_ADDR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; ready is derived from the state we are about to enter.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HDR_ADDR: begin
        if (field_done) begin
          state_next = (word_next[1:0] != 2'b00) ? ST_ERROR : ST_HDR_LEN;
        end
      end
      ST_HDR_LEN: begin
        if (field_done) begin
          if (len_too_big) begin
            state_next = ST_ERROR;
          end else if (len_zero) begin
            state_next = ST_AFTER_LOAD;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (field_done && last_word) begin
          state_next = ST_AFTER_LOAD;
        end
      end
`ifdef CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          state_next = (byte_data_i == xor_reg) ? ST_HOLD : ST_ERROR;
        end
      end
`endif
      ST_HOLD: begin
        if (hold_reg == HW'(RST_HOLD - 1)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN:   state_next = ST_RUN;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_HDR_ADDR;
    endcase

    ready_next = (state_next == ST_HDR_ADDR) || (state_next == ST_HDR_LEN) ||
`ifdef CHECKSUM_EN
                 (state_next == ST_CHECK) ||
`endif
                 (state_next == ST_PAYLOAD);
  end

  // Datapath: byte assembly, header latching, imem write generation and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg      <= 2'd0;
      word_reg     <= 32'd0;
      pc_reg       <= 32'd0;
      n_reg        <= '0;
      idx_reg      <= '0;
      hold_reg     <= '0;
      ready_reg    <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      core_rst_reg <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      ready_reg    <= ready_next;
      we_reg       <= 1'b0;
      core_rst_reg <= (state_next != ST_RUN);
      done_reg     <= (state_next == ST_RUN);
      err_reg      <= (state_next == ST_ERROR);

      // The first HOLD cycle counts as cycle 0 of the reset hold time.
      if (state_reg == ST_HOLD) begin
        hold_reg <= hold_reg + HW'(1);
      end else begin
        hold_reg <= '0;
      end

      if (accept) begin
        cnt_reg  <= cnt_reg + 2'd1;
        word_reg <= word_next;
      end

      if (field_done) begin
        case (state_reg)
          ST_HDR_ADDR: pc_reg <= word_next;
          ST_HDR_LEN: begin
            n_reg   <= word_next[IW-1:0];
            idx_reg <= '0;
          end
          ST_PAYLOAD: begin
            we_reg    <= 1'b1;
            addr_reg  <= pc_reg + {{(30 - IW){1'b0}}, idx_reg, 2'b00};
            wdata_reg <= word_next;
            idx_reg   <= idx_reg + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CHECKSUM_EN
  // Running XOR over every header and payload byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xor_reg <= 8'd0;
    end else if (accept && ((state_reg == ST_HDR_ADDR) || (state_reg == ST_HDR_LEN) ||
                            (state_reg == ST_PAYLOAD))) begin
      xor_reg <= xor_reg ^ byte_data_i;
    end
  end
`endif

  assign byte_ready_o = ready_reg;
  assign imem_we_o    = we_reg;
  assign imem_addr_o  = addr_reg;
  assign imem_wdata_o = wdata_reg;
  assign core_rst_o   = core_rst_reg;
  assign pc_init_o    = pc_reg;
  assign done_o       = done_reg;
  assign err_o        = err_reg;

endmodule
